debug_display: RTL
==================

# debug_display

Front-panel debug block for the single-cycle-stepped processor on the DE2 board. It debounces the step pushbutton into a one-cycle step pulse for the Processor. It snapshots the Processor's debug buses (IR, PC, State, NextState, ALU_A/B/Out) after each step and drives the eight seven-segment digits from a switch-selected source. It is the consumer end of the Processor's debug interface and sits beside the Processor in the top-level Project.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable samples (10 ms at 50 MHz) before a key level is accepted; legal minimum 2.
- Clk  in  1  50 MHz board clock; sole clock.
- Reset  in  1  asynchronous, active-low; clears all state.
- StepKey  in  1  raw KEY input, active-low (0 = pressed), asynchronous to Clk.
- Sel  in  3  source select (SW[17:15]).
- Freeze  in  1  1 = hold current snapshot.
- IR  in  16;  PC  in  8;  State  in  4;  NextState  in  4;  ALU_A, ALU_B, ALU_Out  in  16 each — Processor debug buses.
- StepPulse  out  1  one-Clk-cycle step enable to the Processor.
- StepCount  out  16  number of StepPulses since reset.
- HEX7…HEX0  out  [0:6] each  segments a..g, active-low.

## Operation
- Input path: StepKey → 2-flop synchronizer (flops reset to 1 = released) → debounce FSM.
- FSM states: IDLE (accepted released), PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: sync=0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: sync=0 increments counter; sync=1 → IDLE (bounce); counter = DEBOUNCE_CYCLES−1 with sync=0 → HELD.
  - HELD: sync=1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: mirror of PRESS_WAIT; sync=0 → HELD; stable release → IDLE.
- StepPulse = 1 for exactly the first cycle in HELD. Exactly one pulse per accepted press; releases never pulse.
- StepCount increments on StepPulse, wraps FFFF→0000, counts while frozen.
- Snapshot registers (IR, PC, State, NextState, ALU_A/B/Out) load one cycle after StepPulse (SnapPending), so post-step Processor values are captured. Freeze=1 in the load cycle suppresses the load.
- Display word W by Sel: 0 IR; 1 {8'h00,PC}; 2 {4'h0,State,4'h0,NextState}; 3 ALU_A; 4 ALU_B; 5 ALU_Out; 6 StepCount; 7 16'h0000.
- HEX7 = Sel (hex digit); HEX6 blank; HEX5..HEX4 = snapshot PC; HEX3..HEX0 = W[15:0], HEX0 least significant.
- Hex encoding, active-low [0:6]=a..g: 0=0000001, 1=1001111, 8=0000000, A=0001000, F=0111000; blank=1111111.

## Timing
- Reset values: StepPulse 0, StepCount 0, snapshots 0, FSM IDLE, sync flops 1, all HEX 1111111 (blank).
- Press latency: StepKey falling edge → StepPulse = 2 (sync) + DEBOUNCE_CYCLES cycles.
- Snapshot valid 1 cycle after StepPulse. HEX outputs are registered: Sel/snapshot/StepCount change → HEX updates next cycle.
- First clock after reset deasserts → HEX show Sel and zeros.
- Reset mid-press: FSM returns to IDLE. A key still held after reset is debounced as a new press and pulses once.
- Freeze toggling never alters StepPulse or StepCount.

## Structure
- Package debug_display_pkg: seg7_t (logic [0:6]), SEG_BLANK constant, hex-to-seg7 function, debounce FSM state enum, Sel source constants.
- Sub-module key_debounce: synchronizer, FSM and counter, with counter width $clog2(DEBOUNCE_CYCLES). Output is StepPulse.
- Top debug_display: snapshot registers, StepCount, source mux and registered HEX drivers.

## Test plan (DEBOUNCE_CYCLES=4)
- Reset low 3 cycles, release → all HEX blank during reset; next cycle HEX7=0 and HEX3..0 show 0000 (0000001 each); StepPulse=0.
- Clean press held 20 cycles, then release → single StepPulse 6 cycles after the edge; StepCount=1; no pulse on release.
- Press with 1-cycle bounces at cycles 1 and 3, then stable → one pulse, 4 cycles after the last bounce clears the synchronizer.
- IR=16'hA5F0 applied, step, Sel=0 → HEX3..0 = A,5,F,0 the cycle after the snapshot; Sel=2 with State=3, NextState=4 → 0,3,0,4.
- Freeze=1, step with ALU_Out=16'h1234 → Sel=5 still shows the old value; StepCount increments; Freeze=0, step → 1234 displayed.
- Preload by 65535 steps (or force), step once more → StepCount wraps to 0000. Reset asserted while in PRESS_WAIT → no pulse; holding the key after reset → exactly one pulse.

Source files
------------

// File: rtl/debug_display_pkg.sv
// Shared types and helpers for the front-panel debug display: the seven-segment
// encoding, the debounce FSM states and the display source selects.
package debug_display_pkg;

   typedef logic [0:6] seg7_t;

   localparam seg7_t SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } db_state_e;

   localparam logic [2:0] SEL_IR         = 3'd0;
   localparam logic [2:0] SEL_PC         = 3'd1;
   localparam logic [2:0] SEL_STATE      = 3'd2;
   localparam logic [2:0] SEL_ALU_A      = 3'd3;
   localparam logic [2:0] SEL_ALU_B      = 3'd4;
   localparam logic [2:0] SEL_ALU_OUT    = 3'd5;
   localparam logic [2:0] SEL_STEP_COUNT = 3'd6;
   localparam logic [2:0] SEL_ZERO       = 3'd7;

   // Segments a..g in bit order [0:6], active-low.
   function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
      seg7_t s;
      s = SEG_BLANK;
      case (nib)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/debug_display_key_debounce.sv
// Step pushbutton conditioning: two-flop synchronizer, then a four-state
// debounce FSM that emits one pulse on the first cycle of an accepted press.
module key_debounce
   import debug_display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic step_key,
   output logic step_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_meta;
   logic             key_sync;
   db_state_e        state;
   db_state_e        state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;
   logic             from_press;

   // Flops reset to the released level so a reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= step_key;
         key_sync <= key_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         from_press <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         from_press <= (state == PRESS_WAIT);
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: begin
            if (!key_sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_sync)
               state_d = IDLE;
            else if (cnt == CNT_LAST)
               state_d = HELD;
            else
               cnt_d = cnt + CNT_W'(1);
         end
         HELD: begin
            if (key_sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!key_sync)
               state_d = HELD;
            else if (cnt == CNT_LAST)
               state_d = IDLE;
            else
               cnt_d = cnt + CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // A release bounce re-enters HELD from RELEASE_WAIT and must not pulse.
   always_comb begin
      step_pulse = (state == HELD) && from_press;
   end

endmodule

// File: rtl/debug_display.sv
// Front-panel debug block: debounced step pulse, post-step snapshot of the
// processor debug buses, step counter and registered seven-segment drivers.
module debug_display
   import debug_display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        StepKey,
   input  logic [2:0]  Sel,
   input  logic        Freeze,
   input  logic [15:0] IR,
   input  logic [7:0]  PC,
   input  logic [3:0]  State,
   input  logic [3:0]  NextState,
   input  logic [15:0] ALU_A,
   input  logic [15:0] ALU_B,
   input  logic [15:0] ALU_Out,
   output logic        StepPulse,
   output logic [15:0] StepCount,
   output seg7_t       HEX7,
   output seg7_t       HEX6,
   output seg7_t       HEX5,
   output seg7_t       HEX4,
   output seg7_t       HEX3,
   output seg7_t       HEX2,
   output seg7_t       HEX1,
   output seg7_t       HEX0
);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("DEBOUNCE_CYCLES must be at least 2");
   end

   logic        step_pulse_p0;
   logic        snap_vld_p1;
   logic [15:0] step_cnt;
   logic [15:0] snap_ir_p2;
   logic [7:0]  snap_pc_p2;
   logic [3:0]  snap_state_p2;
   logic [3:0]  snap_next_p2;
   logic [15:0] snap_alu_a_p2;
   logic [15:0] snap_alu_b_p2;
   logic [15:0] snap_alu_out_p2;
   logic [15:0] disp_word;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk       (Clk),
      .rst_n     (Reset),
      .step_key  (StepKey),
      .step_pulse(step_pulse_p0)
   );

   assign StepPulse = step_pulse_p0;
   assign StepCount = step_cnt;

   // Stage p1: the processor commits on the pulse edge, so capture one cycle later.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         snap_vld_p1 <= 1'b0;
         step_cnt    <= '0;
      end else begin
         snap_vld_p1 <= step_pulse_p0;
         if (step_pulse_p0)
            step_cnt <= step_cnt + 16'd1;
      end
   end

   // Stage p2: snapshot registers, held while frozen.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         snap_ir_p2      <= '0;
         snap_pc_p2      <= '0;
         snap_state_p2   <= '0;
         snap_next_p2    <= '0;
         snap_alu_a_p2   <= '0;
         snap_alu_b_p2   <= '0;
         snap_alu_out_p2 <= '0;
      end else if (snap_vld_p1 && !Freeze) begin
         snap_ir_p2      <= IR;
         snap_pc_p2      <= PC;
         snap_state_p2   <= State;
         snap_next_p2    <= NextState;
         snap_alu_a_p2   <= ALU_A;
         snap_alu_b_p2   <= ALU_B;
         snap_alu_out_p2 <= ALU_Out;
      end
   end

   always_comb begin
      disp_word = 16'h0000;
      case (Sel)
         SEL_IR:         disp_word = snap_ir_p2;
         SEL_PC:         disp_word = {8'h00, snap_pc_p2};
         SEL_STATE:      disp_word = {4'h0, snap_state_p2, 4'h0, snap_next_p2};
         SEL_ALU_A:      disp_word = snap_alu_a_p2;
         SEL_ALU_B:      disp_word = snap_alu_b_p2;
         SEL_ALU_OUT:    disp_word = snap_alu_out_p2;
         SEL_STEP_COUNT: disp_word = step_cnt;
         SEL_ZERO:       disp_word = 16'h0000;
         default:        disp_word = 16'h0000;
      endcase
   end

   // Stage p3: registered segment drivers; blank while in reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         HEX7 <= SEG_BLANK;
         HEX6 <= SEG_BLANK;
         HEX5 <= SEG_BLANK;
         HEX4 <= SEG_BLANK;
         HEX3 <= SEG_BLANK;
         HEX2 <= SEG_BLANK;
         HEX1 <= SEG_BLANK;
         HEX0 <= SEG_BLANK;
      end else begin
         HEX7 <= hex_to_seg7({1'b0, Sel});
         HEX6 <= SEG_BLANK;
         HEX5 <= hex_to_seg7(snap_pc_p2[7:4]);
         HEX4 <= hex_to_seg7(snap_pc_p2[3:0]);
         HEX3 <= hex_to_seg7(disp_word[15:12]);
         HEX2 <= hex_to_seg7(disp_word[11:8]);
         HEX1 <= hex_to_seg7(disp_word[7:4]);
         HEX0 <= hex_to_seg7(disp_word[3:0]);
      end
   end

endmodule
